br_cmp_sched: RTL

- Sequencer/arbiter that time-shares one combinational branch comparator between two requesters: the branch unit (port br_) and the set-less-than unit (port slt_).
- Accepts requests with a valid/grant handshake, latches operands, drives the comparator, and samples less/equal.
- Returns a registered result: branch-taken for B-type funct3, or the 0/1 SLT/SLTU result.
- Sits in EX between the decoder-side issue logic and the comparator instance.

---
 rtl/br_cmp_sched_if.sv | 47 ++++
 rtl/br_cmp_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/br_cmp_sched_if.sv
// Request/response and comparator bundle for br_cmp_sched.
// The slave modport is the scheduler; the master modport is issue logic plus the comparator.
interface br_cmp_sched_if #(
    parameter int XLEN = 32
);
    logic            br_req_i;
    logic [2:0]      br_funct3_i;
    logic [XLEN-1:0] br_rs1_i;
    logic [XLEN-1:0] br_rs2_i;
    logic            br_gnt_o;
    logic            br_vld_o;
    logic            br_taken_o;
    logic            br_illegal_o;
    logic            br_rsp_rdy_i;
    logic            br_kill_i;
    logic            slt_req_i;
    logic            slt_unsign_i;
    logic [XLEN-1:0] slt_a_i;
    logic [XLEN-1:0] slt_b_i;
    logic            slt_gnt_o;
    logic            slt_vld_o;
    logic [XLEN-1:0] slt_res_o;
    logic            slt_rsp_rdy_i;
    logic [XLEN-1:0] cmp_rs1_o;
    logic [XLEN-1:0] cmp_rs2_o;
    logic            cmp_unsign_o;
    logic            cmp_less_i;
    logic            cmp_equal_i;

    modport slave (
        input  br_req_i, br_funct3_i, br_rs1_i, br_rs2_i, br_rsp_rdy_i, br_kill_i,
        input  slt_req_i, slt_unsign_i, slt_a_i, slt_b_i, slt_rsp_rdy_i,
        input  cmp_less_i, cmp_equal_i,
        output br_gnt_o, br_vld_o, br_taken_o, br_illegal_o,
        output slt_gnt_o, slt_vld_o, slt_res_o,
        output cmp_rs1_o, cmp_rs2_o, cmp_unsign_o
    );

    modport master (
        output br_req_i, br_funct3_i, br_rs1_i, br_rs2_i, br_rsp_rdy_i, br_kill_i,
        output slt_req_i, slt_unsign_i, slt_a_i, slt_b_i, slt_rsp_rdy_i,
        output cmp_less_i, cmp_equal_i,
        input  br_gnt_o, br_vld_o, br_taken_o, br_illegal_o,
        input  slt_gnt_o, slt_vld_o, slt_res_o,
        input  cmp_rs1_o, cmp_rs2_o, cmp_unsign_o
    );
endinterface

// File: rtl/br_cmp_sched.sv
// Round-robin sequencer sharing one branch comparator between the branch and SLT units.
// Define BR_CMP_SCHED_FAST_EN to drop the CMP state and compare directly at the grant edge.
module br_cmp_sched #(
    parameter int XLEN     = 32,
    parameter bit RSP_HOLD = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    br_cmp_sched_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMP = 2'd1, S_RSP = 2'd2} state_t;
    localparam logic OWN_BR  = 1'b0;
    localparam logic OWN_SLT = 1'b1;

    state_t          r_state, w_state_next;
    logic            r_rr_last, r_owner, r_unsign;
    logic [XLEN-1:0] r_rs1, r_rs2;
    logic            r_taken, r_illegal, r_less;
    logic            w_br_gnt, w_slt_gnt, w_any_gnt;
    logic            w_kill_own, w_rsp_rdy, w_res_load, w_res_owner;
    logic [XLEN-1:0] w_gnt_rs1, w_gnt_rs2;
    logic            w_gnt_unsign;
    logic [2:0]      w_dec_f3;
    logic [1:0]      w_dec;

    // {illegal, taken}
    function automatic logic [1:0] br_decode(input logic [2:0] f3, input logic less,
                                             input logic equal);
        case (f3)
            3'b000:         return {1'b0, equal};
            3'b001:         return {1'b0, ~equal};
            3'b010, 3'b011: return 2'b10;
            3'b100, 3'b110: return {1'b0, less};
            default:        return {1'b0, ~less};
        endcase
    endfunction

    // Tie goes to whichever port did not win last; a killed branch never competes.
    assign w_br_gnt  = (r_state == S_IDLE) && !rst_i && bus.br_req_i && !bus.br_kill_i &&
                       (!bus.slt_req_i || (r_rr_last == OWN_SLT));
    assign w_slt_gnt = (r_state == S_IDLE) && !rst_i && bus.slt_req_i && !w_br_gnt;
    assign w_any_gnt = w_br_gnt || w_slt_gnt;

    assign w_gnt_rs1    = w_br_gnt ? bus.br_rs1_i : bus.slt_a_i;
    assign w_gnt_rs2    = w_br_gnt ? bus.br_rs2_i : bus.slt_b_i;
    assign w_gnt_unsign = w_br_gnt ? bus.br_funct3_i[1] : bus.slt_unsign_i;

    assign w_kill_own = bus.br_kill_i && (r_owner == OWN_BR) && (r_state != S_IDLE);
    assign w_rsp_rdy  = (r_owner == OWN_BR) ? bus.br_rsp_rdy_i : bus.slt_rsp_rdy_i;

`ifdef BR_CMP_SCHED_FAST_EN
    assign bus.cmp_rs1_o    = (r_state == S_IDLE) ? w_gnt_rs1    : r_rs1;
    assign bus.cmp_rs2_o    = (r_state == S_IDLE) ? w_gnt_rs2    : r_rs2;
    assign bus.cmp_unsign_o = (r_state == S_IDLE) ? w_gnt_unsign : r_unsign;
    assign w_res_load  = w_any_gnt;
    assign w_res_owner = w_slt_gnt;
    assign w_dec_f3    = bus.br_funct3_i;
`else
    logic [2:0] r_funct3;
    assign bus.cmp_rs1_o    = r_rs1;
    assign bus.cmp_rs2_o    = r_rs2;
    assign bus.cmp_unsign_o = r_unsign;
    assign w_res_load  = (r_state == S_CMP) && !w_kill_own;
    assign w_res_owner = r_owner;
    assign w_dec_f3    = r_funct3;

    always_ff @(posedge clk_i) begin
        if (rst_i)          r_funct3 <= '0;
        else if (w_any_gnt) r_funct3 <= bus.br_funct3_i;
    end
`endif

    assign w_dec = br_decode(w_dec_f3, bus.cmp_less_i, bus.cmp_equal_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef BR_CMP_SCHED_FAST_EN
                if (w_any_gnt) w_state_next = S_RSP;
`else
                if (w_any_gnt) w_state_next = S_CMP;
`endif
            end
            S_CMP:   w_state_next = w_kill_own ? S_IDLE : S_RSP;
            S_RSP: begin
                if (w_kill_own || !RSP_HOLD || w_rsp_rdy) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.br_gnt_o  = w_br_gnt;
        bus.slt_gnt_o = w_slt_gnt;
        bus.br_vld_o  = 1'b0;
        bus.slt_vld_o = 1'b0;
        if (r_state == S_RSP) begin
            bus.br_vld_o  = (r_owner == OWN_BR) && !bus.br_kill_i;
            bus.slt_vld_o = (r_owner == OWN_SLT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_last <= OWN_SLT;
            r_owner   <= OWN_BR;
            r_unsign  <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
        end else if (w_any_gnt) begin
            r_rr_last <= w_slt_gnt;
            r_owner   <= w_slt_gnt;
            r_unsign  <= w_gnt_unsign;
            r_rs1     <= w_gnt_rs1;
            r_rs2     <= w_gnt_rs2;
        end
    end

    // Only the owning unit's result registers move, so the idle unit's outputs stay put.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_less    <= 1'b0;
        end else if (w_res_load) begin
            if (w_res_owner == OWN_BR) begin
                r_illegal <= w_dec[1];
                r_taken   <= w_dec[0];
            end else begin
                r_less <= bus.cmp_less_i;
            end
        end
    end

    assign bus.br_taken_o   = r_taken;
    assign bus.br_illegal_o = r_illegal;
    assign bus.slt_res_o    = {{(XLEN-1){1'b0}}, r_less};
endmodule
